alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (legal values 32 and 64).
REQ-002 SHALL have parameter TAG_W, default 5, width of the pass-through destination tag.
REQ-003 SHALL have port clk  in  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  in  1  synchronous abort of the in-flight op and the held result.
REQ-006 SHALL have ports in_valid/in_ready  in/out  1  request handshake; transfer when both are high.
REQ-007 SHALL have port in_op  in  alu_op_e  ADD, SUB, SLT, SLTU, AND, OR, XOR, SLL, SRL, SRA, MUL, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port in_w  in  1  32-bit word op with sign-extended result; ignored when XLEN=32.
REQ-009 SHALL have ports in_src1, in_src2  in  XLEN  operands.
REQ-010 SHALL have port in_tag  in  TAG_W  destination id, returned unchanged with the result.
REQ-011 SHALL have ports out_valid/out_ready  out/in  1  result handshake.
REQ-012 SHALL have ports out_data  out  XLEN  and out_tag  out  TAG_W  result and its tag.
REQ-013 SHALL have port busy  out  1  high while the state is ITER.

Function
REQ-014 States SHALL be IDLE and ITER.
REQ-015 in_ready SHALL be high only when state=IDLE and (out_valid=0 or out_ready=1).
REQ-016 Single-cycle ops (ADD..SRA) SHALL load out_data/out_tag on the accept edge, give out_valid=1 the next cycle, and sustain one op per cycle while out_ready=1.
REQ-017 MUL/DIV/DIVU/REM/REMU SHALL move IDLE->ITER on accept, then run N iterations, one per edge: N=32 if in_w or XLEN=32, else XLEN.
REQ-018 The Nth ITER edge SHALL load the result, set out_valid and return the state to IDLE, giving a latency of N cycles.
REQ-019 MUL SHALL be shift-add and SHALL return the low XLEN (or 32, when in_w) bits of the product.
REQ-020 Division SHALL be radix-2 restoring on magnitudes, with signs fixed up on the final edge.
REQ-021 DIV/DIVU with divisor 0 SHALL return all ones; REM/REMU with divisor 0 SHALL return the dividend.
REQ-022 Signed overflow (most-negative / -1) SHALL return the dividend for DIV and 0 for REM.
REQ-023 For in_w ops, operands SHALL be the low 32 bits and the result SHALL be bit31 sign-extended to XLEN.
REQ-024 For in_w shifts, the shift amount SHALL be src2[4:0]; otherwise it SHALL be src2[log2(XLEN)-1:0].
REQ-025 SLT/SLTU SHALL return 0 or 1, zero-extended.
REQ-026 out_valid/out_data/out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 flush=1 SHALL clear out_valid, force the state to IDLE, and keep in_ready=0 that cycle.
REQ-028 A simultaneous in_valid SHALL be dropped when flush=1.
REQ-029 flush SHALL take priority over completion on the same edge.

Reset
REQ-030 rst_n=0 SHALL asynchronously set state=IDLE, out_valid=0, out_data=0, out_tag=0 and busy=0, including mid-iteration.
REQ-031 Iteration counter and partial remainder/product registers SHALL reset to 0.
REQ-032 The first transfer SHALL be possible on the first edge after rst_n rises.

Structure
REQ-033 alu_op_e and the op-class helper (single-cycle vs iterative) SHALL live in the shared package.
REQ-034 The iterative engine SHALL be one sub-module, alu_iter_engine: start, op, w, operands in; done and result out; counter, shift registers and sign fixup inside.
REQ-035 The top level SHALL hold the FSM, handshake, single-cycle datapath and output register.

Verification
REQ-036 XLEN=64, ADD 5+(-7), tag 3, out_ready=1 -> next cycle out_data=0xFFFFFFFFFFFFFFFE, out_tag=3; back-to-back ADDs complete one per cycle.
REQ-037 DIV -20/3 (XLEN=64) -> out_valid exactly 64 cycles after accept, data -6; REM -20/3 -> -2.
REQ-038 DIVU x/0 -> all ones; REM 0x8000000000000000/-1 -> 0; DIV same operands -> 0x8000000000000000.
REQ-039 MUL with in_w=1, 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE after 32 cycles; SRAW 0x80000000 by 4 -> 0xFFFFFFFFF8000000.
REQ-040 out_ready held 0 for 5 cycles after a result -> output stable, in_ready=0; a second request is accepted the cycle out_ready rises.
REQ-041 flush at iteration 10 of DIV, then rst_n pulsed mid-MUL -> no result produced, busy=0, state IDLE; the next ADD completes normally.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared types for the iterative ALU: operation codes, FSM states and the
// helper that splits operations into single-cycle and iterative classes.
package alu_iter_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } alu_state_e;

  // True for operations handled by the multi-cycle engine.
  function automatic logic op_is_iter(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_engine.sv
// Bit-serial multiply (shift-add) and restoring divide. One iteration per
// clock; done is asserted combinationally on the last iteration together
// with the sign-fixed, width-adjusted result.
module alu_iter_engine
  import alu_iter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  alu_op_e         op,
  input  logic            w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

  function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
    logic [XLEN-1:0] r;
    r = XLEN'(v);
    if (v[31]) r = r | HI_MASK;
    return r;
  endfunction

  logic            run_q, w_q, negq_q, negr_q, div0_q;
  logic [CW-1:0]   cnt_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] acc_q, sh_q, b_q;
  logic [XLEN-1:0] acc_d, sh_d, b_d;

  logic            w_eff, sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_v, b_v, a_mag, b_mag, raw;
  logic [XLEN:0]   trial, diff;

  // Operand conditioning: word-op truncation and magnitudes for signed divide.
  always_comb begin
    w_eff = w && (XLEN == 64);
    sgn   = (op == OP_DIV) || (op == OP_REM);
    a_v   = src1;
    b_v   = src2;
    if (w_eff) begin
      a_v = sgn ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
      b_v = sgn ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
    end
    a_neg = sgn && a_v[XLEN-1];
    b_neg = sgn && b_v[XLEN-1];
    a_mag = a_neg ? -a_v : a_v;
    b_mag = b_neg ? -b_v : b_v;
  end

  // One iteration step: shift-add for MUL, restoring subtract for divides.
  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    b_d   = b_q;
    trial = {acc_q, sh_q[XLEN-1]};
    diff  = trial - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      acc_d = acc_q + (sh_q[0] ? b_q : '0);
      sh_d  = sh_q >> 1;
      b_d   = b_q << 1;
    end else if (!diff[XLEN]) begin
      acc_d = diff[XLEN-1:0];
      sh_d  = {sh_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = trial[XLEN-1:0];
      sh_d  = {sh_q[XLEN-2:0], 1'b0};
    end
  end

  // Final-edge selection and sign fixup; a zero divisor keeps the all-ones quotient.
  always_comb begin
    case (op_q)
      OP_DIV, OP_DIVU: raw = (negq_q && !div0_q) ? -sh_d : sh_d;
      OP_REM, OP_REMU: raw = negr_q ? -acc_d : acc_d;
      default:         raw = acc_d;
    endcase
    result = w_q ? sext32(raw[31:0]) : raw;
    done   = run_q && (cnt_q == (w_q ? CW'(31) : CW'(XLEN - 1)));
  end

  // Load operands on start, then iterate until the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      w_q    <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op;
      w_q    <= w_eff;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      div0_q <= (b_mag == '0);
      acc_q  <= '0;
      if (op == OP_MUL) begin
        sh_q <= a_v;
        b_q  <= b_v;
      end else begin
        // Word divides start with the 32-bit dividend in the top half.
        sh_q <= w_eff ? (a_mag << (XLEN - 32)) : a_mag;
        b_q  <= b_mag;
      end
    end else if (run_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Top level: request/result handshake, IDLE/ITER FSM, single-cycle
// datapath and the output register. Multiply/divide go to the engine.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          in_op,
  input  logic             in_w,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

  function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
    logic [XLEN-1:0] r;
    r = XLEN'(v);
    if (v[31]) r = r | HI_MASK;
    return r;
  endfunction

  alu_state_e       state_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_data_q;
  logic [TAG_W-1:0] out_tag_q, pend_tag_q;

  logic             accept, eng_start, eng_done, w_eff;
  logic [XLEN-1:0]  eng_result, a_s, b_s, a_z, raw, sc_result;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign eng_start = accept && op_is_iter(in_op);
  assign busy      = (state_q == ST_ITER);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  // Single-cycle operations; word ops work on the low half and sign-extend.
  always_comb begin
    w_eff = in_w && (XLEN == 64);
    a_s   = w_eff ? sext32(in_src1[31:0]) : in_src1;
    b_s   = w_eff ? sext32(in_src2[31:0]) : in_src2;
    a_z   = w_eff ? XLEN'(in_src1[31:0]) : in_src1;
    shamt = w_eff ? SHW'(in_src2[4:0]) : in_src2[SHW-1:0];
    case (in_op)
      OP_ADD:  raw = a_s + b_s;
      OP_SUB:  raw = a_s - b_s;
      OP_SLT:  raw = XLEN'($signed(a_s) < $signed(b_s));
      OP_SLTU: raw = XLEN'(a_s < b_s);
      OP_AND:  raw = in_src1 & in_src2;
      OP_OR:   raw = in_src1 | in_src2;
      OP_XOR:  raw = in_src1 ^ in_src2;
      OP_SLL:  raw = a_s << shamt;
      OP_SRL:  raw = a_z >> shamt;
      OP_SRA:  raw = $signed(a_s) >>> shamt;
      default: raw = '0;
    endcase
    sc_result = w_eff ? sext32(raw[31:0]) : raw;
  end

  alu_iter_engine #(.XLEN(XLEN)) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (flush),
    .start  (eng_start),
    .op     (in_op),
    .w      (in_w),
    .src1   (in_src1),
    .src2   (in_src2),
    .done   (eng_done),
    .result (eng_result)
  );

  // FSM and output register; flush outranks both acceptance and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      pend_tag_q  <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_is_iter(in_op)) begin
              state_q    <= ST_ITER;
              pend_tag_q <= in_tag;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= sc_result;
              out_tag_q   <= in_tag;
            end
          end
        end
        ST_ITER: begin
          if (eng_done) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            out_data_q  <= eng_result;
            out_tag_q   <= pend_tag_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (XLEN=64): directed requests, a reference model of
// every operation, and a scoreboard process that checks result, tag and
// latency on each cycle the output is valid.
module tb_alu_iter;
  import alu_iter_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready, in_w;
  logic        out_valid, out_ready, busy;
  alu_op_e     in_op;
  logic [63:0] in_src1, in_src2, out_data;
  logic [4:0]  in_tag, out_tag, tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
    bit          seen;
  } exp_t;
  exp_t q[$];

  alu_iter #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_w(in_w),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference behaviour straight from the operation definitions.
  function automatic logic [63:0] model(input alu_op_e op, input bit w,
                                        input logic [63:0] a, input logic [63:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sh;
    logic [63:0]     r, smin;
    if (w) begin
      sa = sx(a[31:0]); sb = sx(b[31:0]);
      ua = {32'b0, a[31:0]}; ub = {32'b0, b[31:0]};
      sh = int'(b[4:0]); smin = 64'hFFFF_FFFF_8000_0000;
    end else begin
      sa = a; sb = b; ua = a; ub = b;
      sh = int'(b[5:0]); smin = 64'h8000_0000_0000_0000;
    end
    case (op)
      OP_ADD:  r = sa + sb;
      OP_SUB:  r = sa - sb;
      OP_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: r = (ua < ub) ? 64'd1 : 64'd0;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = ua << sh;
      OP_SRL:  r = ua >> sh;
      OP_SRA:  r = sa >>> sh;
      OP_MUL:  r = ua * ub;
      OP_DIV:  if (sb == 0) r = '1; else if (sa == smin && sb == -1) r = sa; else r = sa / sb;
      OP_REM:  if (sb == 0) r = sa; else if (sa == smin && sb == -1) r = 0; else r = sa % sb;
      OP_DIVU: if (ub == 0) r = '1; else r = ua / ub;
      OP_REMU: if (ub == 0) r = ua; else r = ua % ub;
      default: r = '0;
    endcase
    if (w) r = sx(r[31:0]);
    return r;
  endfunction

  function automatic int lat(input alu_op_e op, input bit w);
    if (op_is_iter(op)) return w ? 32 : 64;
    return 0;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input alu_op_e op, input bit w, input logic [63:0] a,
                       input logic [63:0] b, output int acc, output int waits);
    exp_t e;
    in_valid = 1'b1; in_op = op; in_w = w; in_src1 = a; in_src2 = b; in_tag = tag;
    acc = -1; waits = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (in_ready) begin
        e.data = model(op, w, a, b); e.tag = tag;
        e.cyc = cyc + 1 + lat(op, w); e.seen = 1'b0;
        q.push_back(e);
        acc = cyc + 1;
        tag = tag + 5'd1;
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      waits++;
      @(negedge clk);
    end
    chk("issue_timeout_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic go(input alu_op_e op, input bit w, input logic [63:0] a, input logic [63:0] b);
    int acc, waits;
    issue(op, w, a, b, acc, waits);
  endtask

  // Scoreboard: compare outputs against the model every valid cycle.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && !flush) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!q[0].seen) begin
            chk("latency_cycle", 64'(cyc), 64'(q[0].cyc));
            q[0].seen = 1'b1;
          end
          chk("out_data", out_data, q[0].data);
          chk("out_tag", 64'(out_tag), 64'(q[0].tag));
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].cyc) begin
        chk("missing_out_valid", 64'(out_valid), 64'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, waits;
    logic [63:0] min64, neg1;
    min64 = 64'h8000_0000_0000_0000;
    neg1  = '1;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_w = 1'b0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1; tag = 5'd3;

    // Model pinned to hand-computed values.
    chk("pin_add",  model(OP_ADD, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_div",  model(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("pin_rem",  model(OP_REM, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_divu0", model(OP_DIVU, 0, 64'd1234, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_removf", model(OP_REM, 0, min64, neg1), 64'd0);
    chk("pin_divovf", model(OP_DIV, 0, min64, neg1), 64'h8000_0000_0000_0000);
    chk("pin_mulw", model(OP_MUL, 1, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_sraw", model(OP_SRA, 1, 64'h8000_0000, 64'd4), 64'hFFFF_FFFF_F800_0000);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts; back-to-back single-cycle ops.
    issue(OP_ADD, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, acc, waits);
    chk("first_accept_waits", 64'(waits), 64'd0);
    go(OP_ADD, 0, 64'd1, 64'd2);
    go(OP_ADD, 0, neg1, 64'd1);
    go(OP_SUB, 0, 64'd0, 64'd1);
    go(OP_SLT, 0, neg1, 64'd1);
    go(OP_SLTU, 0, neg1, 64'd1);
    go(OP_AND, 0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
    go(OP_OR, 0, 64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0010);
    go(OP_XOR, 0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000);
    go(OP_SLL, 0, 64'd1, 64'd63);
    go(OP_SLL, 0, 64'd1, 64'd64);
    go(OP_SRL, 0, min64, 64'd63);
    go(OP_SRA, 0, min64, 64'd63);
    go(OP_ADD, 1, 64'h7FFF_FFFF, 64'd1);
    go(OP_SLL, 1, 64'd1, 64'd31);
    go(OP_SRL, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
    go(OP_SRA, 1, 64'h8000_0000, 64'd4);
    go(OP_SLT, 1, 64'h8000_0000, 64'd1);

    // Iterative ops, each issued as soon as the previous one frees the unit.
    go(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    #1;
    chk("iter_busy", 64'(busy), 64'd1);
    chk("iter_in_ready", 64'(in_ready), 64'd0);
    go(OP_REM, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    go(OP_DIVU, 0, 64'd1234, 64'd0);
    go(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0);
    go(OP_REMU, 0, 64'd77, 64'd0);
    go(OP_REM, 0, min64, neg1);
    go(OP_DIV, 0, min64, neg1);
    go(OP_MUL, 1, 64'h7FFF_FFFF, 64'd2);
    go(OP_MUL, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
    go(OP_MUL, 0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    go(OP_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
    go(OP_REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
    go(OP_DIV, 1, 64'hFFFF_FFF9, 64'd2);
    go(OP_REM, 1, 64'hFFFF_FFF9, 64'd2);
    go(OP_DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF);
    go(OP_DIVU, 1, 64'h1_0000_0064, 64'd0);
    repeat (70) @(negedge clk);

    // Output back-pressure: result holds, next request waits for out_ready.
    out_ready = 1'b0;
    go(OP_ADD, 0, 64'd100, 64'd23);
    in_valid = 1'b1; in_op = OP_SUB; in_w = 1'b0; in_src1 = 64'd50; in_src2 = 64'd8; in_tag = tag;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data", out_data, 64'd123);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(OP_SUB, 0, 64'd50, 64'd8, acc, waits);
    chk("stall_release_waits", 64'(waits), 64'd0);
    repeat (2) @(negedge clk);

    // Flush drops a held result and a simultaneous request.
    out_ready = 1'b0;
    go(OP_ADD, 0, 64'd9, 64'd9);
    flush = 1'b1; q.delete();
    in_valid = 1'b1; in_op = OP_ADD; in_src1 = 64'd1; in_src2 = 64'd1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_held_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Flush at iteration 10 of a divide.
    go(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1; q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_div_busy", 64'(busy), 64'd0);
    chk("flush_div_in_ready", 64'(in_ready), 64'd1);
    repeat (70) @(negedge clk);

    // Flush on the very edge a word divide would complete.
    issue(OP_DIV, 1, 64'd100, 64'd7, acc, waits);
    for (int i = 0; i < 40 && cyc != acc + 31; i++) @(negedge clk);
    flush = 1'b1; q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);
    chk("flush_done_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);

    // Reset pulsed mid-multiply, then a normal ADD.
    go(OP_MUL, 0, 64'd123456, 64'd654321);
    repeat (20) @(negedge clk);
    #3;
    rst_n = 1'b0; q.delete();
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_data", out_data, 64'd0);
    chk("rst_mid_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 0, 64'd40, 64'd2, acc, waits);
    chk("post_reset_waits", 64'(waits), 64'd0);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
